// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and default widths for the SPI master engine
package spi_pkg;

  localparam int unsigned SPI_DATA_W = 32;
  localparam int unsigned SPI_DIV_W  = 8;
  localparam int unsigned SPI_LEN_W  = $clog2(SPI_DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL
  } spi_state_e;

  typedef struct packed {
    logic                 cpol;
    logic                 cpha;
    logic                 lsb_first;
    logic [SPI_LEN_W-1:0] len;
    logic [SPI_DIV_W-1:0] clk_div;
  } spi_cfg_t;

endpackage

// File: rtl/spi_master_engine_clk_gen.sv
// rtl/spi_master_engine_clk_gen.sv - half-period counter, SCLK toggle and edge strobes
module spi_clk_gen #(
  parameter int unsigned LEN_W = 5,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             xfer_i,
  input  logic             cpol_i,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             half_tick_o,
  output logic             lead_edge_o,
  output logic             trail_edge_o,
  output logic             last_edge_o,
  output logic [LEN_W-1:0] bit_idx_o,
  output logic             sclk_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [LEN_W:0]   edge_q, edge_d;
  logic             sclk_q, sclk_d;
  logic             edge_stb;

  // Strobes fire in the cycle before the registered SCLK actually moves.
  always_comb begin
    half_tick_o  = run_i && (cnt_q == clk_div_i);
    edge_stb     = xfer_i && half_tick_o;
    lead_edge_o  = edge_stb && !edge_q[0];
    trail_edge_o = edge_stb && edge_q[0];
    last_edge_o  = (edge_q == {len_i, 1'b1});
    bit_idx_o    = edge_q[LEN_W:1];
    cnt_d        = cnt_q;
    edge_d       = edge_q;
    sclk_d       = sclk_q;
    if (!run_i) begin
      cnt_d  = '0;
      edge_d = '0;
      sclk_d = cpol_i;
    end else begin
      cnt_d = half_tick_o ? '0 : cnt_q + 1'b1;
      if (edge_stb) begin
        edge_d = edge_q + 1'b1;
        sclk_d = ~sclk_q;
      end else if (!xfer_i) begin
        sclk_d = cpol_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      edge_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_master_engine.sv
// rtl/spi_master_engine.sv - SPI master serial engine: transfer FSM and shift registers
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_DATA_W,
  parameter int unsigned LEN_W  = $clog2(DATA_W),
  parameter int unsigned DIV_W  = SPI_DIV_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic [DIV_W-1:0]  clk_div_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              cs_n_o
);

  spi_state_e        state_q, state_d;
  spi_cfg_t          cfg_q, cfg_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic [1:0]        rst_sync_q;
  logic              rst_int_n;
  logic              half_tick, lead_edge, trail_edge, last_edge;
  logic [LEN_W-1:0]  bit_idx;
  logic              drive, sample;
  logic [DATA_W-1:0] tx_aligned;

  // MSB-first words are pre-shifted so the first bit always sits at the top.
  function automatic logic [DATA_W-1:0] align_tx(input logic [DATA_W-1:0] d,
                                                 input logic [LEN_W-1:0]  len,
                                                 input logic              lsb);
    return lsb ? d : d << (LEN_W'(DATA_W - 1) - len);
  endfunction

  function automatic logic head_bit(input logic [DATA_W-1:0] sh, input logic lsb);
    return lsb ? sh[0] : sh[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] sh, input logic lsb);
    return lsb ? (sh >> 1) : (sh << 1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  spi_clk_gen #(
    .LEN_W(LEN_W),
    .DIV_W(DIV_W)
  ) u_clk_gen (
    .clk         (clk),
    .rst_n       (rst_int_n),
    .run_i       (busy_o),
    .xfer_i      (state_q == XFER),
    .cpol_i      (busy_o ? cfg_q.cpol : cpol_i),
    .clk_div_i   (DIV_W'(cfg_q.clk_div)),
    .len_i       (LEN_W'(cfg_q.len)),
    .half_tick_o (half_tick),
    .lead_edge_o (lead_edge),
    .trail_edge_o(trail_edge),
    .last_edge_o (last_edge),
    .bit_idx_o   (bit_idx),
    .sclk_o      (sclk_o)
  );

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_d       = rx_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;
    drive      = 1'b0;
    sample     = 1'b0;
    tx_aligned = align_tx(tx_data_i, len_i, lsb_first_i);
    unique case (state_q)
      IDLE: begin
        mosi_d = 1'b0;
        if (start_i) begin
          cfg_d.cpol      = cpol_i;
          cfg_d.cpha      = cpha_i;
          cfg_d.lsb_first = lsb_first_i;
          cfg_d.len       = SPI_LEN_W'(len_i);
          cfg_d.clk_div   = SPI_DIV_W'(clk_div_i);
          rx_sh_d         = '0;
          state_d         = LEAD;
          // cpha=0 presents the first bit before the first SCLK edge.
          if (cpha_i) begin
            tx_d = tx_aligned;
          end else begin
            mosi_d = head_bit(tx_aligned, lsb_first_i);
            tx_d   = shift_tx(tx_aligned, lsb_first_i);
          end
        end
      end
      LEAD: begin
        if (half_tick) state_d = XFER;
      end
      XFER: begin
        drive  = cfg_q.cpha ? lead_edge : (trail_edge && !last_edge);
        sample = cfg_q.cpha ? trail_edge : lead_edge;
        if (drive) begin
          mosi_d = head_bit(tx_q, cfg_q.lsb_first);
          tx_d   = shift_tx(tx_q, cfg_q.lsb_first);
        end
        if (sample) begin
          if (cfg_q.lsb_first) rx_sh_d[bit_idx] = miso_i;
          else                 rx_sh_d = {rx_sh_q[DATA_W-2:0], miso_i};
        end
        if (trail_edge && last_edge) state_d = TRAIL;
      end
      TRAIL: begin
        if (half_tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
          mosi_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign cs_n_o    = (state_q == IDLE);
  assign done_o    = done_q;
  assign rx_data_o = rx_q;
  assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// tb/tb_spi_master_engine.sv - directed self-checking bench with SPI slave agent
module tb_spi_master_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] tx_data_i = '0;
  logic [4:0]  len_i = '0;
  logic        cpol_i = 1'b0, cpha_i = 1'b0, lsb_first_i = 1'b0;
  logic [7:0]  clk_div_i = '0;
  logic        busy_o, done_o, sclk_o, mosi_o, cs_n_o, miso_i;
  logic [31:0] rx_data_o;

  int n_chk = 0, n_err = 0;

  spi_master_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .tx_data_i  (tx_data_i),
    .len_i      (len_i),
    .cpol_i     (cpol_i),
    .cpha_i     (cpha_i),
    .lsb_first_i(lsb_first_i),
    .clk_div_i  (clk_div_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rx_data_o  (rx_data_o),
    .sclk_o     (sclk_o),
    .mosi_o     (mosi_o),
    .miso_i     (miso_i),
    .cs_n_o     (cs_n_o)
  );

  always #5 clk = ~clk;

  // Slave agent: drives miso from sl_word, captures mosi on its sample edges.
  logic        lb = 1'b0, sl_miso = 1'b0, sl_cpol = 1'b0, sl_cpha = 1'b0, sl_lsb = 1'b0;
  logic [31:0] sl_word = '0, mosi_seq = '0;
  logic        cap [0:63];
  int          sl_len = 0, sl_bit = 0, n_cap = 0;

  assign miso_i = lb ? mosi_o : sl_miso;

  task automatic sl_drive();
    if (sl_bit <= sl_len) sl_miso = sl_lsb ? sl_word[sl_bit] : sl_word[sl_len - sl_bit];
    else                  sl_miso = 1'b0;
    sl_bit++;
  endtask

  always @(negedge cs_n_o) begin
    sl_bit = 0; n_cap = 0; mosi_seq = '0;
    if (!sl_cpha) sl_drive();
  end

  always @(sclk_o) begin
    if (!cs_n_o && rst_n) begin
      if ((sclk_o != sl_cpol) == sl_cpha) sl_drive();
      else begin
        mosi_seq = {mosi_seq[30:0], mosi_o};
        if (n_cap < 64) cap[n_cap] = mosi_o;
        n_cap++;
      end
    end
  end

  // Monitor sampled on the inactive edge.
  int   cyc = 0, t_busy = 0, t_done = 0, n_done = 0;
  int   cs_low = 0, cs_len = 0, cs_high = 0, cs_gap = 0, n_edges = 0, n_rise = 0;
  int   et [0:1];
  logic busy_p = 1'b0, cs_p = 1'b1, sclk_p = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (busy_o && !busy_p) t_busy = cyc;
    if (done_o) begin t_done = cyc; n_done++; end
    if (!cs_n_o) begin
      if (cs_p) begin cs_low = 0; n_edges = 0; n_rise = 0; cs_gap = cs_high; end
      cs_low++;
      if (sclk_o != sclk_p) begin
        if (n_edges < 2) et[n_edges] = cyc;
        n_edges++;
        if (sclk_o) n_rise++;
      end
    end else begin
      if (!cs_p) cs_len = cs_low;
      cs_high = cs_p ? cs_high + 1 : 1;
    end
    busy_p = busy_o; cs_p = cs_n_o; sclk_p = sclk_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_o && n < 5000) begin step(); n++; end
    if (!done_o) chk({tag, " done timeout"}, {31'd0, done_o}, 32'd1);
  endtask

  task automatic setup(input logic [31:0] tx, input int len, input logic cpol, input logic cpha,
                       input logic lsb, input int div, input logic [31:0] sw, input logic loop);
    tx_data_i = tx; len_i = 5'(len); cpol_i = cpol; cpha_i = cpha; lsb_first_i = lsb;
    clk_div_i = 8'(div);
    sl_word = sw; sl_len = len; sl_cpol = cpol; sl_cpha = cpha; sl_lsb = lsb; lb = loop;
    step();
  endtask

  task automatic run(input logic [31:0] tx, input int len, input logic cpol, input logic cpha,
                     input logic lsb, input int div, input logic [31:0] sw, input logic loop,
                     input string tag);
    setup(tx, len, cpol, cpha, lsb, div, sw, loop);
    start_i = 1'b1; step(); start_i = 1'b0;
    wait_done(tag);
  endtask

  int          nd0, td1, n;
  logic [31:0] r1;

  initial begin
    repeat (3) step();
    chk("rst cs_n", {31'd0, cs_n_o}, 32'd1);
    chk("rst sclk", {31'd0, sclk_o}, 32'd0);
    chk("rst mosi", {31'd0, mosi_o}, 32'd0);
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst done", {31'd0, done_o}, 32'd0);
    chk("rst rx", rx_data_o, 32'd0);
    rst_n = 1'b1;
    repeat (4) step();

    nd0 = n_done;
    run(32'hA5, 7, 0, 0, 0, 0, 32'h0, 1, "m0");
    chk("m0 mosi seq", mosi_seq, 32'hA5);
    chk("m0 rising", n_rise, 8);
    chk("m0 rx", rx_data_o, 32'hA5);
    chk("m0 latency", t_done - t_busy, 18);
    chk("m0 done count", n_done - nd0, 1);

    cpol_i = 1'b1; step();
    chk("m3 idle sclk", {31'd0, sclk_o}, 32'd1);
    run(32'h1234, 15, 1, 1, 0, 3, 32'hBEEF, 0, "m3");
    chk("m3 half period", et[1] - et[0], 4);
    chk("m3 rx", rx_data_o, 32'hBEEF);
    chk("m3 latency", t_done - t_busy, 136);
    chk("m3 cs low", cs_len, 136);
    chk("m3 mosi seq", mosi_seq, 32'h1234);

    run(32'h80000001, 31, 0, 1, 1, 0, 32'hCAFEF00D, 0, "m1");
    chk("m1 first bit", {31'd0, cap[0]}, 32'd1);
    chk("m1 second bit", {31'd0, cap[1]}, 32'd0);
    chk("m1 rx", rx_data_o, 32'hCAFEF00D);

    nd0 = n_done;
    setup(32'h3C, 7, 0, 0, 0, 1, 32'h5A, 0);
    start_i = 1'b1; step(); start_i = 1'b0;
    repeat (6) step();
    tx_data_i = 32'hFF; start_i = 1'b1; step(); start_i = 1'b0;
    wait_done("busy");
    chk("busy rx", rx_data_o, 32'h5A);
    repeat (40) step();
    chk("busy done count", n_done - nd0, 1);
    chk("busy idle", {31'd0, busy_o}, 32'd0);
    chk("busy mosi seq", mosi_seq, 32'h3C);

    setup(32'h96, 7, 0, 0, 0, 3, 32'h0, 1);
    start_i = 1'b1; step(); start_i = 1'b0;
    n = 0;
    while (n_edges < 5 && n < 500) begin step(); n++; end
    chk("rst edge reached", n_edges, 5);
    nd0 = n_done;
    rst_n = 1'b0; #1;
    chk("abort cs_n", {31'd0, cs_n_o}, 32'd1);
    chk("abort sclk", {31'd0, sclk_o}, 32'd0);
    chk("abort busy", {31'd0, busy_o}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("abort no done", n_done - nd0, 0);
    chk("abort rx", rx_data_o, 32'h0);
    run(32'h69, 7, 0, 0, 0, 0, 32'h0, 1, "post rst");
    chk("post rst rx", rx_data_o, 32'h69);

    setup(32'h11, 7, 0, 0, 0, 0, 32'h0, 1);
    start_i = 1'b1;
    wait_done("b2b first");
    r1 = rx_data_o; td1 = t_done;
    tx_data_i = 32'h22;
    step(); start_i = 1'b0;
    chk("b2b busy", {31'd0, busy_o}, 32'd1);
    wait_done("b2b second");
    chk("b2b first rx", r1, 32'h11);
    chk("b2b restart", t_busy - td1, 1);
    chk("b2b cs gap", cs_gap, 1);
    chk("b2b second rx", rx_data_o, 32'h22);

    run(32'h1, 0, 1, 0, 0, 1, 32'h1, 0, "len0");
    chk("len0 edges", n_edges, 2);
    chk("len0 rx", rx_data_o, 32'h1);
    chk("len0 latency", t_done - t_busy, 8);
    chk("len0 mosi", mosi_seq, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
